pwm_avs_csr: RTL and testbench
==============================

Name: pwm_avs_csr

Overview:
- Avalon-MM slave register front end that sits directly upstream of the pwm core and drives its period and duty_cycle inputs.
- Host writes land in shadow registers. They are committed to the active outputs only at a PWM cycle boundary, so the core never sees a torn or mid-cycle update.
- Optional duty ramping (soft start/stop) moves the active duty toward the target by a programmable step once per PWM cycle.
- Keeps a boundary counter in lockstep with the pwm core; cycle length is active period + 2 clocks.

Parameters:
- DW, 32, data and register width.
- RESET_PERIOD, 0, reset value of the shadow and active period.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset. Shared with the pwm core instance.
- avs_address  in  3  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  DW  write data.
- avs_byteenable  in  DW/8  byte lanes for writes.
- avs_readdata  out  DW  read data, fixed latency 1.
- period_o  out  DW  active period, to pwm period.
- duty_o  out  DW  active duty, to pwm duty_cycle.
- pwm_en_o  out  1  CTRL.enable, used to gate pwm_o at the top level.
- period_tick_o  out  1  one-cycle pulse on the last clock of each PWM cycle.

Behaviour:
- Register map (word addresses):
  - 0 CTRL rw: bit0 enable, bit1 ramp_en.
  - 1 PERIOD rw: shadow period.
  - 2 DUTY rw: target duty.
  - 3 RAMP_STEP rw.
  - 4 STATUS ro: bit0 update_pending, bit1 ramp_busy.
  - 5 ACTIVE_DUTY ro.
  - 6-7 reserved: read 0, writes ignored.
- Writes: byte lanes honoured per avs_byteenable. Writes to read-only or reserved addresses have no effect. No waitrequest; every access completes in one cycle.
- Reads: avs_readdata is registered. The value sampled at the edge where avs_read=1 appears on the next cycle. When no read is in progress, avs_readdata holds its last value.
- Reset:
  - CTRL=0, PERIOD shadow and period_o = RESET_PERIOD, all other registers 0.
  - duty_o=0, pwm_en_o=0, period_tick_o=0, avs_readdata=0, boundary counter bcnt=0.
- Boundary counter (tracks the pwm core exactly):
  - enable=1: if bcnt > period_o then bcnt<=0, else bcnt<=bcnt+1.
  - period_tick_o = enable AND (bcnt > period_o). This is combinational from registered state and matches the pwm core's wrap cycle.
  - enable=0: bcnt forced to 0 and period_tick_o=0.
- update_pending: set by any write to PERIOD or DUTY. Cleared at commit unless a PERIOD or DUTY write occurs on the same cycle.
- Commit happens on any clock with period_tick_o=1, or on every clock while enable=0. At commit, period_o <= PERIOD shadow, and duty_o is updated as follows:
  - ramp_en=0 or RAMP_STEP=0: duty_o <= target.
  - ramp_en=1, duty_o < target: duty_o <= min(duty_o+RAMP_STEP, target). The addition uses DW+1 bits, so overflow saturates at target.
  - ramp_en=1, duty_o > target: duty_o <= max(duty_o-RAMP_STEP, target). Borrow saturates at target.
  - While enable=0, duty_o follows target directly (no ramp).
- ramp_busy = ramp_en AND (duty_o != target).
- Simultaneous host write and commit: commit uses the pre-write shadow value, and the new value waits for the next boundary.
- Enable 0->1: bcnt starts from 0 on the next cycle with already-committed values; the first tick occurs after period_o+2 clocks.
- Enable 1->0: bcnt clears on the next edge.
- Duty greater than period is legal; it passes through unclamped and pwm_o stays high.
- Period changes take effect only at a boundary, so the bcnt>period_o comparison never sees a mid-cycle change.
- Reset asserted mid-operation: all state returns to reset values on that edge, and any pending update is discarded.

Test Plan:
1. Reset, then read addresses 0-7 -> every readdata is 0 one cycle after each read (with RESET_PERIOD=0); period_o=0, duty_o=0.
2. enable=0, write PERIOD=10 and DUTY=4 -> period_o=10 and duty_o=4 one cycle after each write; STATUS reads 0.
3. enable=1, period 10; write DUTY=7 at bcnt=3 -> duty_o stays 4 until the edge where bcnt=11, then becomes 7; update_pending reads 1 before that edge and 0 after; ticks repeat every 12 clocks.
4. Ramp: ramp_en=1, RAMP_STEP=3, duty 0 -> target 10 with period 20 -> duty_o goes 3, 6, 9, 10 on successive ticks; ramp_busy falls after the tick that loads 10. Then target 0 -> duty_o goes 7, 4, 1, 0.
5. Byteenable: write 0xAABBCCDD to PERIOD with byteenable=0b0011 over shadow 0x11223344 -> shadow reads 0x1122CCDD.
6. Collision and reset: write PERIOD=5 on the exact tick cycle -> the old period is committed, pending stays 1, and 5 commits at the next tick. Assert reset mid-cycle -> all outputs return to reset values on that edge.

Source files
------------

// File: rtl/pwm_avs_csr_if.sv
// Avalon-MM slave bus bundle between the host fabric and the PWM CSR block.
interface pwm_avs_csr_if #(
  parameter int DW = 32
);
  logic [2:0]      address;
  logic            read;
  logic            write;
  logic [DW-1:0]   writedata;
  logic [DW/8-1:0] byteenable;
  logic [DW-1:0]   readdata;

  modport master (output address, read, write, writedata, byteenable, input readdata);
  modport slave  (input address, read, write, writedata, byteenable, output readdata);
endinterface

// File: rtl/pwm_avs_csr.sv
// PWM CSR front end: shadowed period/duty committed at PWM cycle boundaries,
// optional per-cycle duty ramping, and a boundary counter that runs in
// lockstep with the downstream pwm core (cycle length = period_o + 2).
module pwm_avs_csr #(
  parameter int            DW           = 32,
  parameter logic [DW-1:0] RESET_PERIOD = '0
) (
  input  logic          clk,
  input  logic          reset,
  pwm_avs_csr_if.slave  avs,
  output logic [DW-1:0] period_o,
  output logic [DW-1:0] duty_o,
  output logic          pwm_en_o,
  output logic          period_tick_o
);
  localparam int NB = DW/8;

  logic [1:0]    ctrl;        // {ramp_en, enable}
  logic [DW-1:0] period_sh;
  logic [DW-1:0] target;
  logic [DW-1:0] ramp_step;
  logic [DW-1:0] bcnt;
  logic          pending;
  logic [DW-1:0] wmask;
  logic [DW-1:0] duty_nx;
  logic [DW-1:0] rd_mux;
  logic [DW:0]   up_sum;
  logic [DW:0]   dn_diff;
  logic          ramp_busy;
  logic          commit;
  logic          wr_ctrl, wr_period, wr_duty, wr_step;

  // Expand byte enables into a bit mask for read-modify-write of shadows.
  for (genvar b = 0; b < NB; b++) begin : g_be
    assign wmask[b*8 +: 8] = {8{avs.byteenable[b]}};
  end

  assign wr_ctrl   = avs.write && (avs.address == 3'd0);
  assign wr_period = avs.write && (avs.address == 3'd1);
  assign wr_duty   = avs.write && (avs.address == 3'd2);
  assign wr_step   = avs.write && (avs.address == 3'd3);

  assign pwm_en_o      = ctrl[0];
  assign period_tick_o = ctrl[0] && (bcnt > period_o);
  // While disabled the outputs track the shadows every clock.
  assign commit        = period_tick_o || !ctrl[0];
  assign ramp_busy     = ctrl[1] && (duty_o != target);

  // One extra bit on both sides so overflow/borrow saturate at target.
  assign up_sum  = {1'b0, duty_o} + {1'b0, ramp_step};
  assign dn_diff = {1'b0, duty_o} - {1'b0, ramp_step};

  // Next active duty at a commit: jump to target, or one ramp step toward it.
  always_comb begin
    duty_nx = target;
    if (ctrl[0] && ctrl[1] && (ramp_step != '0)) begin
      if (duty_o < target)
        duty_nx = (up_sum > {1'b0, target}) ? target : up_sum[DW-1:0];
      else if (duty_o > target)
        duty_nx = (dn_diff[DW] || (dn_diff[DW-1:0] < target)) ? target : dn_diff[DW-1:0];
    end
  end

  // Register file read mux; reserved words read as zero.
  always_comb begin
    rd_mux = '0;
    case (avs.address)
      3'd0:    rd_mux[1:0] = ctrl;
      3'd1:    rd_mux      = period_sh;
      3'd2:    rd_mux      = target;
      3'd3:    rd_mux      = ramp_step;
      3'd4:    rd_mux[1:0] = {ramp_busy, pending};
      3'd5:    rd_mux      = duty_o;
      default: rd_mux      = '0;
    endcase
  end

  // Host-visible shadow registers with byte-lane writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl      <= '0;
      period_sh <= RESET_PERIOD;
      target    <= '0;
      ramp_step <= '0;
    end else begin
      if (wr_ctrl && avs.byteenable[0]) ctrl <= avs.writedata[1:0];
      if (wr_period) period_sh <= (period_sh & ~wmask) | (avs.writedata & wmask);
      if (wr_duty)   target    <= (target    & ~wmask) | (avs.writedata & wmask);
      if (wr_step)   ramp_step <= (ramp_step & ~wmask) | (avs.writedata & wmask);
    end
  end

  // Commit shadows to the active outputs; a same-cycle write stays pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_o <= RESET_PERIOD;
      duty_o   <= '0;
      pending  <= 1'b0;
    end else begin
      if (commit) begin
        period_o <= period_sh;
        duty_o   <= duty_nx;
      end
      if (wr_period || wr_duty) pending <= 1'b1;
      else if (commit)          pending <= 1'b0;
    end
  end

  // Boundary counter mirroring the pwm core's wrap.
  always_ff @(posedge clk) begin
    if (reset || !ctrl[0]) bcnt <= '0;
    else if (period_tick_o) bcnt <= '0;
    else                    bcnt <= bcnt + 1'b1;
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk) begin
    if (reset)         avs.readdata <= '0;
    else if (avs.read) avs.readdata <= rd_mux;
  end
endmodule

// File: tb/tb_pwm_avs_csr.sv
// Bench for pwm_avs_csr: directed table, hand sequences for boundary corner
// cases, then random traffic against a cycle-level behavioural model.
module tb_pwm_avs_csr;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] period_o, duty_o;
  logic        pwm_en_o, period_tick_o;

  pwm_avs_csr_if #(.DW(32)) avs_bus();

  pwm_avs_csr #(.DW(32), .RESET_PERIOD(32'd0)) dut (
    .clk(clk), .reset(reset), .avs(avs_bus),
    .period_o(period_o), .duty_o(duty_o),
    .pwm_en_o(pwm_en_o), .period_tick_o(period_tick_o)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  logic        m_en, m_ramp, m_pend;
  logic [31:0] m_per_sh, m_tgt, m_step, m_per, m_duty, m_rd;
  longint      m_bcnt;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd_val(input logic [2:0] a);
    case (a)
      3'd0: return {30'd0, m_ramp, m_en};
      3'd1: return m_per_sh;
      3'd2: return m_tgt;
      3'd3: return m_step;
      3'd4: return {30'd0, m_ramp && (m_duty != m_tgt), m_pend};
      3'd5: return m_duty;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_tick();
    return m_en && (m_bcnt > longint'(m_per));
  endfunction

  task automatic model_reset();
    m_en = 0; m_ramp = 0; m_pend = 0;
    m_per_sh = 0; m_tgt = 0; m_step = 0; m_per = 0; m_duty = 0; m_rd = 0; m_bcnt = 0;
  endtask

  task automatic model_step(input logic [2:0] a, input logic rd, input logic wr,
                            input logic [31:0] wd, input logic [3:0] be);
    logic   commit = m_tick() || !m_en;
    longint d = m_duty, t = m_tgt, s = m_step;
    logic [31:0] nduty = m_duty, nper = m_per;
    if (rd) m_rd = rd_val(a);
    if (commit) begin
      nper = m_per_sh;
      if (!m_en || !m_ramp || s == 0) nduty = m_tgt;
      else if (d < t) nduty = (d + s > t) ? m_tgt : 32'(d + s);
      else if (d > t) nduty = (d - s < t) ? m_tgt : 32'(d - s);
    end
    if (!m_en || m_tick()) m_bcnt = 0; else m_bcnt++;
    if (wr && (a == 3'd1 || a == 3'd2)) m_pend = 1;
    else if (commit) m_pend = 0;
    m_per = nper; m_duty = nduty;
    if (wr) case (a)
      3'd0: if (be[0]) {m_ramp, m_en} = wd[1:0];
      3'd1: m_per_sh = merge(m_per_sh, wd, be);
      3'd2: m_tgt    = merge(m_tgt, wd, be);
      3'd3: m_step   = merge(m_step, wd, be);
      default: ;
    endcase
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("period_o", period_o, m_per);
    chk("duty_o", duty_o, m_duty);
    chk("pwm_en_o", {31'd0, pwm_en_o}, {31'd0, m_en});
    chk("period_tick_o", {31'd0, period_tick_o}, {31'd0, m_tick()});
    chk("readdata", avs_bus.readdata, m_rd);
  endtask

  task automatic cyc(input logic [2:0] a, input logic rd, input logic wr,
                     input logic [31:0] wd, input logic [3:0] be);
    avs_bus.address = a; avs_bus.read = rd; avs_bus.write = wr;
    avs_bus.writedata = wd; avs_bus.byteenable = be;
    @(posedge clk);
    model_step(a, rd, wr, wd, be);
    #1;
    chk_model();
  endtask

  task automatic idle();
    cyc(3'd0, 1'b0, 1'b0, 32'd0, 4'h0);
  endtask

  task automatic rst_cyc();
    reset = 1'b1;
    avs_bus.read = 0; avs_bus.write = 0;
    @(posedge clk);
    model_reset();
    #1;
    chk_model();
    reset = 1'b0;
  endtask

  // Advance idle cycles until the tick is visible; returns cycles spent.
  task automatic wait_tick(input int lim, output int n);
    n = 0;
    while (!period_tick_o && n < lim) begin idle(); n++; end
    checks++;
    if (!period_tick_o) begin
      errors++;
      $display("FAIL wait_tick: no tick within %0d cycles", lim);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [2:0]  a;
    logic        rd, wr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] e_per, e_duty, e_rd;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] a, input logic rd, input logic wr,
                              input logic [31:0] wd, input logic [3:0] be,
                              input logic [31:0] e_per, input logic [31:0] e_duty,
                              input logic [31:0] e_rd);
    vec_t v;
    v.a = a; v.rd = rd; v.wr = wr; v.wd = wd; v.be = be;
    v.e_per = e_per; v.e_duty = e_duty; v.e_rd = e_rd;
    return v;
  endfunction

  vec_t tbl[24];

  initial begin
    int n;
    logic [31:0] up_exp[4];
    logic [31:0] dn_exp[4];
    up_exp = '{32'd3, 32'd6, 32'd9, 32'd10};
    dn_exp = '{32'd7, 32'd4, 32'd1, 32'd0};

    for (int i = 0; i < 8; i++) tbl[i] = mk(3'(i), 1, 0, 0, 4'h0, 0, 0, 0);
    tbl[8]  = mk(3'd1, 0, 1, 32'd10, 4'hF, 0, 0, 0);
    tbl[9]  = mk(3'd0, 0, 0, 0, 4'h0, 10, 0, 0);
    tbl[10] = mk(3'd2, 0, 1, 32'd4, 4'hF, 10, 0, 0);
    tbl[11] = mk(3'd0, 0, 0, 0, 4'h0, 10, 4, 0);
    tbl[12] = mk(3'd4, 1, 0, 0, 4'h0, 10, 4, 0);
    tbl[13] = mk(3'd1, 1, 0, 0, 4'h0, 10, 4, 10);
    tbl[14] = mk(3'd2, 1, 0, 0, 4'h0, 10, 4, 4);
    tbl[15] = mk(3'd1, 0, 1, 32'h11223344, 4'hF, 10, 4, 4);
    tbl[16] = mk(3'd1, 0, 1, 32'hAABBCCDD, 4'h3, 32'h11223344, 4, 4);
    tbl[17] = mk(3'd1, 1, 0, 0, 4'h0, 32'h1122CCDD, 4, 32'h1122CCDD);
    tbl[18] = mk(3'd1, 0, 1, 32'd10, 4'hF, 32'h1122CCDD, 4, 32'h1122CCDD);
    tbl[19] = mk(3'd0, 0, 0, 0, 4'h0, 10, 4, 32'h1122CCDD);
    tbl[20] = mk(3'd6, 0, 1, 32'hDEADBEEF, 4'hF, 10, 4, 32'h1122CCDD);
    tbl[21] = mk(3'd6, 1, 0, 0, 4'h0, 10, 4, 0);
    tbl[22] = mk(3'd5, 0, 1, 32'h0000FFFF, 4'hF, 10, 4, 0);
    tbl[23] = mk(3'd5, 1, 0, 0, 4'h0, 10, 4, 4);

    avs_bus.address = 0; avs_bus.read = 0; avs_bus.write = 0;
    avs_bus.writedata = 0; avs_bus.byteenable = 0;
    model_reset();
    rst_cyc();
    rst_cyc();

    foreach (tbl[i]) begin
      cyc(tbl[i].a, tbl[i].rd, tbl[i].wr, tbl[i].wd, tbl[i].be);
      chk($sformatf("tbl%0d_per", i), period_o, tbl[i].e_per);
      chk($sformatf("tbl%0d_duty", i), duty_o, tbl[i].e_duty);
      chk($sformatf("tbl%0d_rd", i), avs_bus.readdata, tbl[i].e_rd);
    end

    // Enable with period 10: first tick 11 cycles after the enable edge.
    cyc(3'd0, 0, 1, 32'd1, 4'hF);
    wait_tick(50, n);
    chk("first_tick_gap", n, 11);
    idle();
    n = 0;
    while (m_bcnt != 3 && n < 50) begin idle(); n++; end
    cyc(3'd2, 0, 1, 32'd7, 4'hF);
    chk("duty_held", duty_o, 4);
    cyc(3'd4, 1, 0, 0, 4'h0);
    chk("pending_set", avs_bus.readdata, 1);
    wait_tick(50, n);
    chk("tick_gap_mid", n, 6);
    chk("duty_held_at_tick", duty_o, 4);
    idle();
    chk("duty_commit", duty_o, 7);
    cyc(3'd4, 1, 0, 0, 4'h0);
    chk("pending_clr", avs_bus.readdata, 0);
    wait_tick(50, n);
    chk("tick_period12", n + 2, 12);

    // Ramp up 0->10 and back down with step 3, period 20.
    cyc(3'd0, 0, 1, 32'd0, 4'hF);
    cyc(3'd2, 0, 1, 32'd0, 4'hF);
    cyc(3'd1, 0, 1, 32'd20, 4'hF);
    cyc(3'd3, 0, 1, 32'd3, 4'hF);
    idle();
    chk("ramp_setup_per", period_o, 20);
    chk("ramp_setup_duty", duty_o, 0);
    cyc(3'd0, 0, 1, 32'd3, 4'hF);
    cyc(3'd2, 0, 1, 32'd10, 4'hF);
    for (int k = 0; k < 4; k++) begin
      wait_tick(100, n);
      idle();
      chk($sformatf("ramp_up%0d", k), duty_o, up_exp[k]);
      cyc(3'd4, 1, 0, 0, 4'h0);
      chk($sformatf("ramp_busy_up%0d", k), {31'd0, avs_bus.readdata[1]}, (k < 3) ? 1 : 0);
    end
    cyc(3'd2, 0, 1, 32'd0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      wait_tick(100, n);
      idle();
      chk($sformatf("ramp_dn%0d", k), duty_o, dn_exp[k]);
    end

    // Write on the exact tick cycle: old period commits, new one waits.
    wait_tick(100, n);
    cyc(3'd1, 0, 1, 32'd5, 4'hF);
    chk("collide_old_per", period_o, 20);
    cyc(3'd4, 1, 0, 0, 4'h0);
    chk("collide_pending", {31'd0, avs_bus.readdata[0]}, 1);
    wait_tick(100, n);
    idle();
    chk("collide_new_per", period_o, 5);
    idle(); idle(); idle();
    rst_cyc();
    chk("rst_per", period_o, 0);
    chk("rst_duty", duty_o, 0);
    chk("rst_en", {31'd0, pwm_en_o}, 0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      int r = $urandom_range(0, 99);
      logic [2:0]  a  = 3'($urandom_range(0, 7));
      logic [31:0] wd;
      logic [3:0]  be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      case (a)
        3'd0: wd = 32'($urandom_range(0, 3));
        3'd1: wd = ($urandom_range(0, 49) == 0) ? 32'($urandom) : 32'($urandom_range(0, 15));
        3'd3: wd = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFF0 : 32'($urandom_range(0, 6));
        default: wd = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15))
                                                  : 32'($urandom_range(0, 24));
      endcase
      if (r < 1)       rst_cyc();
      else if (r < 40) idle();
      else if (r < 65) cyc(a, 1, 0, 32'd0, 4'h0);
      else             cyc(a, 0, 1, wd, be);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
